// File: rtl/moving_sum_pkg.sv
// Shared definitions for the moving-sum encoder/decoder pair.
//   clogb2()     : ceiling log2, used to size sum words and fill counters
//   dec_state_e  : decoder state encoding
//   DEFAULT_*    : default sample width and window length shared with the encoder
package moving_sum_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } dec_state_e;

    // Ceiling log2; clogb2(1) = 0, clogb2(8) = 3, clogb2(9) = 4.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_history_line.sv
// DEPTH x WIDTH shift register holding the most recent decoded samples.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift din into stage 0 this cycle
//   clear      : synchronous clear of every stage (wins over en)
//   din        : sample entering the line
//   tail       : oldest stage, x[n-DEPTH] relative to the sample being decoded
module sample_history_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tail
);

    logic [WIDTH-1:0] x_h_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                x_h_q[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                x_h_q[k] <= '0;
            end
        end else if (en) begin
            x_h_q[0] <= din;
            for (int k = 1; k < int'(DEPTH); k++) begin
                x_h_q[k] <= x_h_q[k-1];
            end
        end
    end

    assign tail = x_h_q[DEPTH-1];

endmodule

// File: rtl/moving_sum_decoder.sv
// Reconstructs samples x[n] from a DEPTH-tap running-sum stream y[n] using
// x[n] = y[n] - y[n-1] + x[n-DEPTH], assuming the encoder started from an
// all-zero history. One clock of latency, no backpressure.
// DEPTH must be a power of two and at least 2.
// Optional macro MOVING_SUM_DEC_CHECK_EN: when defined, a reconstructed value
// outside 0..2^WIDTH-1 raises a sticky o_err (state ERR); when undefined the
// output is a silent modulo-2^WIDTH truncation and o_err is tied low.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous clear of history, state and flags (ignores i_valid)
//   i_valid    : i_sum carries a new sum word
//   i_sum      : running-sum word y[n]
//   o_valid    : o_data valid this cycle (one cycle after each accept)
//   o_data     : reconstructed sample x[n]
//   o_locked   : at least DEPTH samples decoded since reset/clear
//   o_err      : sticky range-violation flag
module moving_sum_decoder
    import moving_sum_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned YWD   = WIDTH + clogb2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [YWD-1:0]   i_sum,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_locked,
    output logic             o_err
);

    localparam int unsigned CW = clogb2(DEPTH) + 1;
    localparam int unsigned DW = YWD + 2;

    logic [YWD-1:0]   y_prev_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    dec_state_e       state_q, state_d;

    logic             accept;
    logic [WIDTH-1:0] tail;
    logic [DW-1:0]    diff;
    logic [WIDTH-1:0] sample;
    logic             range_viol;

    assign accept = i_valid & ~i_clear;

    // Two guard bits keep the signed difference exact for any pair of sum words.
    assign diff   = {2'b00, i_sum} - {2'b00, y_prev_q} + {{(DW-WIDTH){1'b0}}, tail};
    assign sample = diff[WIDTH-1:0];

`ifdef MOVING_SUM_DEC_CHECK_EN
    // Negative (sign bit) or any bit set above the sample width.
    assign range_viol = diff[DW-1] | (|diff[DW-2:WIDTH]);
`else
    logic unused_diff;
    assign unused_diff = ^diff[DW-1:WIDTH];
    assign range_viol  = 1'b0;
`endif

    sample_history_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_history (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clear (i_clear),
        .din   (sample),
        .tail  (tail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_prev_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (i_clear) begin
            y_prev_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                y_prev_q <= i_sum;
                data_q   <= sample;
                if (cnt_q != CW'(DEPTH)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = IDLE;
        end else if (accept) begin
            unique case (state_q)
                IDLE, RUN: state_d = range_viol ? ERR : RUN;
                ERR:       state_d = ERR;
                default:   state_d = IDLE;
            endcase
        end
    end

    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_locked = (cnt_q == CW'(DEPTH));

`ifdef MOVING_SUM_DEC_CHECK_EN
    assign o_err = (state_q == ERR);
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Directed bench for moving_sum_decoder (WIDTH=8, DEPTH=8, YWD=11).
// Inputs are driven 1 time unit after the rising edge; outputs are compared
// 1 time unit after the edge that registers them.
module tb_moving_sum_decoder;

`ifdef MOVING_SUM_DEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_clear;
    logic        i_valid;
    logic [10:0] i_sum;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_locked;
    logic        o_err;

    int checks;
    int errors;

    moving_sum_decoder #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (i_clear),
        .i_valid  (i_valid),
        .i_sum    (i_sum),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_locked (o_locked),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input and wait until just after the edge that samples it.
    task automatic drive(input logic v, input int s, input logic c);
        i_valid = v;
        i_sum   = 11'(s);
        i_clear = c;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic do_clear();
        drive(1'b1, 77, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_locked !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_flags: valid=%b locked=%b err=%b required 0 0 0",
                     o_valid, o_locked, o_err);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_sum   = '0;
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_locked !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h locked=%b err=%b required 0 00 0 0",
                     o_valid, o_data, o_locked, o_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b required 0", o_valid);
        end
    endtask

    task automatic test_constant();
        int s;
        do_clear();
        for (int i = 0; i < 12; i++) begin
            s = (i < 8) ? 5 * (i + 1) : 40;
            drive(1'b1, s, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'd5 || o_locked !== (i >= 7) || o_err !== 1'b0)
            begin
                errors++;
                $display("FAIL constant[%0d]: valid=%b data=%0d locked=%b err=%b required 1 5 %b 0",
                         i, o_valid, o_data, o_locked, o_err, (i >= 7));
            end
        end
        drive(1'b0, 40, 1'b0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL constant_tail_valid: got %b required 0", o_valid);
        end
    endtask

    task automatic test_impulse();
        logic [7:0] exp_d;
        do_clear();
        for (int i = 0; i < 14; i++) begin
            exp_d = (i == 0) ? 8'd100 : 8'd0;
            drive(1'b1, (i < 8) ? 100 : 0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_d || o_err !== 1'b0) begin
                errors++;
                $display("FAIL impulse[%0d]: valid=%b data=%0d err=%b required 1 %0d 0",
                         i, o_valid, o_data, o_err, exp_d);
            end
        end
    endtask

    task automatic test_gapped();
        int k;
        logic v;
        do_clear();
        k = 0;
        for (int i = 0; i < 20; i++) begin
            v = (i % 2 == 0);
            // Idle cycles carry a junk sum that must not be consumed.
            drive(v, v ? ((k < 8) ? 5 * (k + 1) : 40) : 999, 1'b0);
            if (v) k++;
            checks++;
            if (o_valid !== v || (v && o_data !== 8'd5) || o_locked !== (k >= 8)) begin
                errors++;
                $display("FAIL gapped[%0d]: valid=%b data=%0d locked=%b required %b 5 %b",
                         i, o_valid, o_data, o_locked, v, (k >= 8));
            end
        end
    endtask

    task automatic test_range_violation();
        do_clear();
        drive(1'b1, 10, 1'b0);
        checks++;
        if (o_data !== 8'd10 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL viol_first: data=%h err=%b required 0a 0", o_data, o_err);
        end
        drive(1'b1, 3, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hF9 || o_err !== CHK) begin
            errors++;
            $display("FAIL viol_neg: valid=%b data=%h err=%b required 1 f9 %b",
                     o_valid, o_data, o_err, CHK);
        end
        drive(1'b1, 3, 1'b0);
        checks++;
        if (o_data !== 8'd0 || o_err !== CHK) begin
            errors++;
            $display("FAIL viol_sticky: data=%h err=%b required 00 %b", o_data, o_err, CHK);
        end
        // Clear with a valid word present: the word must be dropped.
        drive(1'b1, 50, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_err !== 1'b0 || o_locked !== 1'b0 || o_data !== 8'd0) begin
            errors++;
            $display("FAIL viol_clear: valid=%b err=%b locked=%b data=%h required 0 0 0 00",
                     o_valid, o_err, o_locked, o_data);
        end
        drive(1'b1, 7, 1'b0);
        checks++;
        if (o_data !== 8'd7 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL after_clear: data=%0d err=%b required 7 0", o_data, o_err);
        end
        // A violating word arriving together with clear must not set o_err.
        drive(1'b1, 0, 1'b1);
        checks++;
        if (o_err !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_beats_viol: err=%b valid=%b required 0 0", o_err, o_valid);
        end
        drive(1'b0, 0, 1'b0);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_beats_viol_hold: err=%b required 0", o_err);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        drive(1'b1, 300, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h2C || o_err !== CHK) begin
            errors++;
            $display("FAIL overflow: valid=%b data=%h err=%b required 1 2c %b",
                     o_valid, o_data, o_err, CHK);
        end
        drive(1'b0, 0, 1'b0);
        checks++;
        if (o_err !== CHK || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_hold: err=%b valid=%b required %b 0", o_err, o_valid, CHK);
        end
    endtask

    task automatic test_reset_midstream();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5 * (i + 1), 1'b0);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'd0 || o_locked !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset: valid=%b data=%h locked=%b err=%b required 0 00 0 0",
                     o_valid, o_data, o_locked, o_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i < 8) ? 5 * (i + 1) : 40, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'd5 || o_locked !== (i >= 7)) begin
                errors++;
                $display("FAIL restart[%0d]: valid=%b data=%0d locked=%b required 1 5 %b",
                         i, o_valid, o_data, o_locked, (i >= 7));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_constant();
        test_impulse();
        test_gapped();
        test_range_violation();
        test_overflow();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
